// File: rtl/program_map_pkg.sv
// Shared types and helpers for the program-memory region selector.
// Holds the access-sequencer state encoding, the idle chip-enable constant
// and the width helpers used by the top and the address decoder.
package program_map_pkg;

  // Access sequencer phases
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACTIVE = 3'd2,
    RESP   = 3'd3,
    TURN   = 3'd4
  } state_t;

  // Widest chip-enable bus supported; users slice the low NUM_REGIONS bits
  localparam int CE_MAX_W = 64;

  // All chip enables released (active-low, so all ones)
  localparam logic [CE_MAX_W-1:0] CE_IDLE_ALL = '1;

  // Binary region-index width: never narrower than one bit
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Larger of two integers, used to size the shared phase counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/program_region_decode.sv
// Address-to-region decoder: index, range check and write-protect hit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the sequencer samples the outputs only at accept.
// Optional feature macro: WRITE_PROTECT_EN enables the protect_hit path.
module program_region_decode
  import program_map_pkg::*;
#(
  parameter int                     ADDR_W       = 32,
  parameter int                     NUM_REGIONS  = 2,
  parameter int                     REGION_SHIFT = 27,
  parameter int                     SEL_W        = sel_width(NUM_REGIONS),
  parameter logic [NUM_REGIONS-1:0] WP_MASK      = '0
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  output logic [SEL_W-1:0]  index,
  output logic              in_range,
  output logic              protect_hit
);

  localparam int IDX_W = ADDR_W - REGION_SHIFT;

  logic [IDX_W-1:0] w_full_idx;
  logic             w_unused_low;

  // Region number is everything above the region-size bits
  assign w_full_idx = addr[ADDR_W-1:REGION_SHIFT];

  // Offset within a region does not affect selection
  assign w_unused_low = ^addr[REGION_SHIFT-1:0];

  // Full-width compare so any set bit above SEL_W forces an error
  assign in_range = (64'(w_full_idx) < 64'(NUM_REGIONS));

  // Only meaningful when in_range is set
  assign index = SEL_W'(w_full_idx);

`ifdef WRITE_PROTECT_EN
  // Writes into a protected region are refused; reads pass untouched
  assign protect_hit = write & in_range & WP_MASK[index];
`else
  logic w_unused_wp;

  // Writes sequence exactly like reads; the mask has no effect
  assign w_unused_wp = write ^ (^WP_MASK);
  assign protect_hit = 1'b0;
`endif

endmodule

// File: rtl/program_region_select.sv
// Program-flash region selector: decodes fetch address, sequences one-hot CE_n.
// Latency: accept-to-resp 2+WAIT_CYCLES (error: 1); accept-to-ready 3+WAIT_CYCLES+TURNAROUND (error: 2+TURNAROUND).
// Backpressure: req_ready only in IDLE; master holds req_valid; no queueing. Macro: WRITE_PROTECT_EN.
module program_region_select
  import program_map_pkg::*;
#(
  parameter int                     ADDR_W       = 32,
  parameter int                     NUM_REGIONS  = 2,
  parameter int                     REGION_SHIFT = 27,
  parameter int                     WAIT_CYCLES  = 3,
  parameter int                     TURNAROUND   = 1,
  parameter logic [NUM_REGIONS-1:0] WP_MASK      = '0,
  // Derived width of chip_select; leave at its default
  parameter int                     SEL_W        = sel_width(NUM_REGIONS)
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   req_valid,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic                   req_write,
  output logic                   req_ready,
  output logic                   resp_valid,
  output logic                   resp_err,
  output logic [NUM_REGIONS-1:0] flash_ce_n,
  output logic [SEL_W-1:0]       chip_select,
  output logic                   busy
);

  // One counter serves both the wait and turnaround phases
  localparam int                     CNT_W    = $clog2(max_int(WAIT_CYCLES, TURNAROUND) + 1);
  localparam logic [CNT_W-1:0]       CNT_WAIT = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0]       CNT_TURN = CNT_W'(TURNAROUND);
  localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_REGIONS-1:0] CE_IDLE  = CE_IDLE_ALL[NUM_REGIONS-1:0];

  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [NUM_REGIONS-1:0]   r_ce_n;
  logic [SEL_W-1:0]         r_sel;
  logic                     r_ready;
  logic                     r_resp_vld;
  logic                     r_resp_err;

  logic [SEL_W-1:0]         w_index;
  logic                     w_in_range;
  logic                     w_protect_hit;
  logic [NUM_REGIONS-1:0]   w_ce_active;

  program_region_decode #(
    .ADDR_W       (ADDR_W),
    .NUM_REGIONS  (NUM_REGIONS),
    .REGION_SHIFT (REGION_SHIFT),
    .SEL_W        (SEL_W),
    .WP_MASK      (WP_MASK)
  ) u_decode (
    .addr        (req_addr),
    .write       (req_write),
    .index       (w_index),
    .in_range    (w_in_range),
    .protect_hit (w_protect_hit)
  );

  // Active-low one-hot enable for the region latched at accept
  assign w_ce_active = ~(NUM_REGIONS'(1) << r_sel);

  // Sequencer: state, phase counter and every output register move together
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ce_n     <= CE_IDLE;
      r_sel      <= '0;
      r_ready    <= 1'b1;
      r_resp_vld <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_ready <= 1'b0;
            if (w_in_range && !w_protect_hit) begin
              r_state <= SETUP;
              r_sel   <= w_index;
            end else begin
              // Refused access: skip the flash entirely, chip_select keeps its value
              r_state    <= RESP;
              r_resp_vld <= 1'b1;
              r_resp_err <= 1'b1;
            end
          end
        end

        SETUP: begin
          r_state <= ACTIVE;
          r_cnt   <= CNT_WAIT;
          r_ce_n  <= w_ce_active;
        end

        ACTIVE: begin
          if (r_cnt == CNT_ONE) begin
            r_state    <= RESP;
            r_ce_n     <= CE_IDLE;
            r_resp_vld <= 1'b1;
            r_resp_err <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        RESP: begin
          r_resp_vld <= 1'b0;
          r_resp_err <= 1'b0;
          if (TURNAROUND == 0) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            r_state <= TURN;
            r_cnt   <= CNT_TURN;
          end
        end

        TURN: begin
          if (r_cnt == CNT_ONE) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        default: begin
          r_state    <= IDLE;
          r_ce_n     <= CE_IDLE;
          r_ready    <= 1'b1;
          r_resp_vld <= 1'b0;
          r_resp_err <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = r_ready;
  assign busy        = ~r_ready;
  assign resp_valid  = r_resp_vld;
  assign resp_err    = r_resp_err;
  assign flash_ce_n  = r_ce_n;
  assign chip_select = r_sel;

endmodule
